// File: rtl/adder_pkg.sv
// Shared definitions for the adder_acc slice: operand/beat widths and FSM state encoding.
package adder_pkg;

  localparam int unsigned OPND_W = 6;
  localparam int unsigned BEAT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/adder_acc_adder.sv
// Existing combinational 6-bit adder; {cout, s} is the 7-bit beat sum.
module adder_acc_adder
  import adder_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [OPND_W-1:0] s,
  output logic              cout
);

  assign {cout, s} = a + b;

endmodule

// File: rtl/adder_acc.sv
// Burst accumulator: sums x+y beats until last, then holds the result until consumed.
// Define ADDER_ACC_SAT_EN to clamp acc at its maximum on overflow instead of wrapping.
module adder_acc
  import adder_pkg::*;
#(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic [OPND_W-1:0]  w_s;
  logic               w_cout;
  logic [BEAT_W-1:0]  w_beat;
  logic [ACC_W:0]     w_sum;
  logic               w_ovf_now;
  logic               w_take;
  logic [ACC_W-1:0]   w_acc_nxt;

  adder_acc_adder u_adder (
    .a    (x),
    .b    (y),
    .s    (w_s),
    .cout (w_cout)
  );

  assign w_beat    = {w_cout, w_s};
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - BEAT_W){1'b0}}, w_beat};
  assign w_ovf_now = w_sum[ACC_W];
  assign w_take    = in_valid && r_in_ready;

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
`ifdef ADDER_ACC_SAT_EN
    // Once overflowed, acc stays pinned at max for the rest of the burst.
    if (r_ovf || w_ovf_now) begin
      w_acc_nxt = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACC: begin
          if (w_take) begin
            r_acc   <= w_acc_nxt;
            r_count <= (r_count == '1) ? r_count : r_count + 1'b1;
            r_ovf   <= r_ovf | w_ovf_now;
            if (last) begin
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACC;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_acc       <= '0;
          r_count     <= '0;
          r_ovf       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc       = r_acc;
  assign count     = r_count;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_acc.sv
// Directed self-checking bench for adder_acc; inputs driven and outputs sampled on the falling edge.
module tb_adder_acc;

`ifdef ADDER_ACC_SAT_EN
  localparam logic [31:0] EXP_OVF_ACC = 32'd4095;
`else
  localparam logic [31:0] EXP_OVF_ACC = 32'd62;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  x;
  logic [5:0]  y;
  logic        last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] acc;
  logic [7:0]  count;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  adder_acc #(
    .ACC_W (12),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .count     (count),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [5:0] bx, input logic [5:0] by, input logic bl);
    @(negedge clk);
    in_valid = 1'b1;
    x        = bx;
    y        = by;
    last     = bl;
    @(negedge clk);
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("consume_ov", out_valid, 0);
    check("consume_acc", acc, 0);
    check("consume_cnt", count, 0);
    check("consume_ovf", ovf, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    last      = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);

    // Single maximal beat
    send(6'd63, 6'd63, 1'b1);
    check("single_ov", out_valid, 1);
    check("single_acc", acc, 126);
    check("single_cnt", count, 1);
    check("single_ovf", ovf, 0);
    check("single_rdy", in_ready, 0);
    consume();

    // Three-beat burst
    send(6'd1, 6'd2, 1'b0);
    send(6'd3, 6'd4, 1'b0);
    check("burst_mid_ov", out_valid, 0);
    check("burst_mid_acc", acc, 10);
    check("burst_mid_cnt", count, 2);
    send(6'd5, 6'd6, 1'b1);
    check("burst_ov", out_valid, 1);
    check("burst_acc", acc, 21);
    check("burst_cnt", count, 3);
    check("burst_ovf", ovf, 0);

    // HOLD backpressure with input pressing
    in_valid = 1'b1;
    x        = 6'd5;
    y        = 6'd5;
    last     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rdy", in_ready, 0);
      check("hold_ov", out_valid, 1);
      check("hold_acc", acc, 21);
      check("hold_cnt", count, 3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_rel_ov", out_valid, 0);
    check("hold_rel_acc", acc, 0);
    check("hold_rel_cnt", count, 0);
    check("hold_rel_rdy", in_ready, 1);
    in_valid = 1'b0;
    last     = 1'b0;

    // Overflow: 33 beats of 126 = 4158
    for (int i = 0; i < 32; i++) send(6'd63, 6'd63, 1'b0);
    check("ovf32_acc", acc, 4032);
    check("ovf32_flag", ovf, 0);
    check("ovf32_cnt", count, 32);
    send(6'd63, 6'd63, 1'b1);
    check("ovf_ov", out_valid, 1);
    check("ovf_acc", acc, EXP_OVF_ACC);
    check("ovf_flag", ovf, 1);
    check("ovf_cnt", count, 33);

    // Consume then new beat on the very next cycle
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 6'd1;
    y         = 6'd1;
    last      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    last     = 1'b0;
    check("b2b_ov", out_valid, 1);
    check("b2b_acc", acc, 2);
    check("b2b_cnt", count, 1);
    check("b2b_ovf", ovf, 0);
    consume();

    // Reset mid-burst
    send(6'd7, 6'd8, 1'b0);
    send(6'd9, 6'd10, 1'b0);
    check("mid_cnt", count, 2);
    check("mid_acc", acc, 34);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_ov", out_valid, 0);
    check("mrst_acc", acc, 0);
    check("mrst_cnt", count, 0);
    check("mrst_rdy", in_ready, 1);
    send(6'd2, 6'd3, 1'b1);
    check("mrst_new_ov", out_valid, 1);
    check("mrst_new_acc", acc, 5);
    check("mrst_new_cnt", count, 1);
    consume();

    // Count saturation: 300 beats of 0+1
    for (int i = 0; i < 299; i++) send(6'd0, 6'd1, 1'b0);
    check("sat_mid_ov", out_valid, 0);
    send(6'd0, 6'd1, 1'b1);
    check("sat_ov", out_valid, 1);
    check("sat_cnt", count, 255);
    check("sat_acc", acc, 300);
    check("sat_ovf", ovf, 0);
    consume();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_acc.md
ADDER_ACC -- requirements
Module: adder_acc

Interface
REQ-001 Parameter ACC_W, default 12: accumulator width in bits; minimum 7.
REQ-002 Parameter CNT_W, default 8: beat counter width in bits.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous, active-low.
REQ-005 Port in_valid  input  1: operand pair x, y (with last) is presented.
REQ-006 Port in_ready  output  1: block accepts an operand pair this cycle.
REQ-007 Port x  input  6: first operand, unsigned.
REQ-008 Port y  input  6: second operand, unsigned.
REQ-009 Port last  input  1: the accepted beat is the final beat of a burst.
REQ-010 Port out_valid  output  1: acc, count and ovf hold a completed burst result.
REQ-011 Port out_ready  input  1: consumer takes the result.
REQ-012 Port acc  output  ACC_W: running or final burst sum.
REQ-013 Port count  output  CNT_W: number of beats accepted in the current burst.
REQ-014 Port ovf  output  1: sticky accumulator overflow flag for the current burst.

Function
REQ-015 A beat SHALL be accepted exactly when in_valid && in_ready at a rising edge of clk.
REQ-016 The beat sum SHALL be the 7-bit value {cout, s} from the existing 6-bit adder, i.e. x + y in the range 0..126.
REQ-017 The FSM SHALL have three states: IDLE, ACC, HOLD.
REQ-018 IDLE: in_ready=1, out_valid=0; on an accepted beat, go to ACC, or to HOLD if last=1.
REQ-019 ACC: in_ready=1, out_valid=0; on an accepted beat with last=1, go to HOLD.
REQ-020 HOLD: in_ready=0, out_valid=1; acc, count and ovf held stable; on out_ready=1, clear acc, count and ovf, then go to IDLE.
REQ-021 Accumulate step: acc <= acc + zero-extended beat sum, applied in the same edge as acceptance; the last beat is included.
REQ-022 Latency: out_valid SHALL rise on the cycle after the edge that accepts the last beat.
REQ-023 Overflow: if the true sum exceeds 2^ACC_W-1, ovf SHALL be set and remain set until the result is consumed or reset.
REQ-024 Count SHALL saturate at 2^CNT_W-1; counting past that value SHALL NOT set ovf.
REQ-025 The block SHALL accept no input in HOLD, and SHALL accept a new beat in the cycle following the HOLD-to-IDLE transition.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL go to IDLE with acc=0, count=0, ovf=0 and out_valid=0, from any state, including mid-burst or in HOLD.
REQ-027 A partial burst interrupted by reset SHALL be discarded and SHALL NOT produce out_valid.

Configuration
REQ-028 With ADDER_ACC_SAT_EN defined, on overflow acc SHALL clamp to 2^ACC_W-1, stay clamped for the rest of the burst, and set ovf.
REQ-029 Without ADDER_ACC_SAT_EN, acc SHALL wrap modulo 2^ACC_W and set ovf.

Structure
REQ-030 The FSM state encodings, the operand width (6) and the beat-sum width (7) SHALL reside in the shared package adder_pkg.
REQ-031 adder_acc SHALL instantiate the existing combinational adder as its single sub-module; no other sub-modules.

Verification
REQ-032 Single beat x=63, y=63, last=1 -> next cycle out_valid=1, acc=126, count=1, ovf=0.
REQ-033 Burst (1,2), (3,4), (5,6) with last on the third beat -> acc=21, count=3, ovf=0.
REQ-034 HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable; the result is consumed on the first out_ready=1.
REQ-035 33 beats of 63+63 -> true sum 4158; without the macro acc=62, ovf=1; with ADDER_ACC_SAT_EN acc=4095, ovf=1; count=33 in both cases.
REQ-036 rst_n=0 for one cycle after 2 accepted beats -> IDLE, acc=0, count=0, out_valid=0; a new single beat 2+3 with last=1 -> acc=5.
REQ-037 out_ready=1 in HOLD, then a new beat 1+1 with last=1 on the next cycle -> acc=2, count=1, with no carry-over from the prior burst.
